// File: rtl/jk_ctrl_pkg.sv
// Shared encodings for the JK bank controller: command opcodes and FSM states.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_COUNT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_APPLY = 2'b01,
    S_COUNT = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: 00 hold, 10 set, 01 clear, 11 toggle; async active-low reset.
module jk_cell (
  input  logic CLK,
  input  logic RST_N,
  input  logic J,
  input  logic K,
  output logic Q
);

  logic q_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q <= 1'b0;
    end else begin
      case ({J, K})
        2'b10:   q_q <= 1'b1;
        2'b01:   q_q <= 1'b0;
        2'b11:   q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer driving a bank of JK cells: hold, masked set/clear, or
// a synchronous binary up-count of programmable length.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_MASK,
  input  logic [CNT_W-1:0] CMD_COUNT,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] j, k, tgl;
  logic             accept;

  assign accept = CMD_VALID && (state_q == S_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command payload needs no reset: it is only consumed after an accept.
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_q   <= op_e'(CMD_OP);
      mask_q <= CMD_MASK;
    end
  end

  // Ripple-carry toggle enables for a synchronous binary up-counter.
  always_comb begin
    tgl[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tgl[i] = tgl[i-1] & Q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j       = '0;
    k       = '0;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          cnt_d = CMD_COUNT;
          if (op_e'(CMD_OP) != OP_COUNT) begin
            state_d = S_APPLY;
          end else if (CMD_COUNT == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COUNT;
          end
        end
      end
      S_APPLY: begin
        case (op_q)
          OP_SET:   j = mask_q;
          OP_CLEAR: k = mask_q;
          default:  ;
        endcase
        state_d = S_DONE;
      end
      S_COUNT: begin
        j     = tgl;
        k     = tgl;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign CMD_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_DONE);

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .CLK  (CLK),
      .RST_N(RST_N),
      .J    (j[g]),
      .K    (k[g]),
      .Q    (Q[g])
    );
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl (WIDTH=4): command table plus scoreboard of expected
// final Q and DONE latency, and hand-written multi-cycle corner sequences.
module tb_jk_bank_ctrl;

  localparam logic [1:0] HOLD  = 2'b00;
  localparam logic [1:0] SET   = 2'b01;
  localparam logic [1:0] CLEAR = 2'b10;
  localparam logic [1:0] COUNT = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [7:0] cmd_count;
  logic [3:0] q;
  logic       busy;
  logic       done;

  jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CMD_VALID(cmd_valid),
    .CMD_READY(cmd_ready),
    .CMD_OP   (cmd_op),
    .CMD_MASK (cmd_mask),
    .CMD_COUNT(cmd_count),
    .Q        (q),
    .BUSY     (busy),
    .DONE     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] mask;
    logic [7:0] cnt;
    logic [3:0] exp_q;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    int         lat;
    int         acc;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[12];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   busy_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    sb_t e;
    if (busy) busy_cnt++;
    if (done) begin
      chk("done_ready_exclusive", int'(cmd_ready), 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("q_at_done", int'(q), int'(e.q));
        chk("done_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] mask, input logic [7:0] cnt,
                      input logic [3:0] eq, input int el, output int waited);
    sb_t e;
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_count = cnt;
    while (!cmd_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", waited, 0);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    e.q   = eq;
    e.lat = el;
    e.acc = cyc;
    sb.push_back(e);
    busy_cnt = 0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb.size() != 0 || !cmd_ready) && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) chk("idle_timeout", g, 0);
  endtask

  initial begin
    int w;
    logic [3:0] seq[5];

    vecs[0]  = '{SET,   4'b1010, 8'd0,   4'b1010, 1};
    vecs[1]  = '{CLEAR, 4'b0010, 8'd0,   4'b1000, 1};
    vecs[2]  = '{HOLD,  4'b1111, 8'd0,   4'b1000, 1};
    vecs[3]  = '{SET,   4'b0110, 8'd0,   4'b1110, 1};
    vecs[4]  = '{COUNT, 4'b0000, 8'd5,   4'b0011, 5};
    vecs[5]  = '{COUNT, 4'b1111, 8'd0,   4'b0011, 0};
    vecs[6]  = '{CLEAR, 4'b1111, 8'd0,   4'b0000, 1};
    vecs[7]  = '{COUNT, 4'b0000, 8'd1,   4'b0001, 1};
    vecs[8]  = '{SET,   4'b0000, 8'd0,   4'b0001, 1};
    vecs[9]  = '{COUNT, 4'b0000, 8'd20,  4'b0101, 20};
    vecs[10] = '{COUNT, 4'b0000, 8'd255, 4'b0100, 255};
    vecs[11] = '{CLEAR, 4'b0100, 8'd0,   4'b0000, 1};

    // Reset with a command presented: nothing may be accepted.
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = SET;
    cmd_mask  = 4'b1111;
    cmd_count = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q", int'(q), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_q", int'(q), 0);

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].mask, vecs[i].cnt, vecs[i].exp_q, vecs[i].exp_lat, w);
      wait_idle();
      chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].exp_q));
      chk($sformatf("vec%0d_busy_cycles", i), busy_cnt, vecs[i].exp_lat + 1);
    end

    // COUNT 5 from 1110 with wrap, checked edge by edge.
    send(SET, 4'b1110, 8'd0, 4'b1110, 1, w);
    wait_idle();
    seq[0] = 4'b1111; seq[1] = 4'b0000; seq[2] = 4'b0001; seq[3] = 4'b0010; seq[4] = 4'b0011;
    send(COUNT, 4'b0000, 8'd5, 4'b0011, 5, w);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("count5_step%0d", i), int'(q), int'(seq[i]));
    end
    wait_idle();
    chk("count5_busy_cycles", busy_cnt, 6);

    // COUNT 0 followed by a command held against back-pressure.
    send(COUNT, 4'b0000, 8'd0, 4'b0011, 0, w);
    send(SET, 4'b0100, 8'd0, 4'b0111, 1, w);
    chk("backpressure_waited", int'(w > 0), 1);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("backpressure_once_q", int'(q), 4'b0111);
    chk("backpressure_idle", int'(busy), 0);

    // Reset in the middle of a COUNT 10.
    send(CLEAR, 4'b1111, 8'd0, 4'b0000, 1, w);
    wait_idle();
    send(COUNT, 4'b0000, 8'd10, 4'b1010, 10, w);
    repeat (3) @(posedge clk);
    #1;
    chk("midcount_q", int'(q), 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_q", int'(q), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("after_abort_ready", int'(cmd_ready), 1);
    send(SET, 4'b0001, 8'd0, 4'b0001, 1, w);
    wait_idle();
    chk("after_abort_set_q", int'(q), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Command-driven sequencer for a bank of WIDTH JK flip-flops. It accepts one command at a time over a valid/ready handshake and drives every cell's J/K pair each cycle. Supported commands are hold, masked set, masked clear, or a synchronous binary up-count of programmable length. It is the control layer that turns the team's JK cells into a usable register/counter resource for upstream logic.

## Interface
Parameters:
- WIDTH, 4, number of JK cells in the bank (1..16)
- CNT_W, 8, width of the count-length field

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous, active-low reset
- CMD_VALID  input  1  command present
- CMD_READY  output  1  block can accept a command
- CMD_OP  input  2  00 HOLD, 01 SET, 10 CLEAR, 11 COUNT
- CMD_MASK  input  WIDTH  per-bit select for SET/CLEAR; ignored for HOLD/COUNT
- CMD_COUNT  input  CNT_W  number of count steps for COUNT; ignored otherwise
- Q  output  WIDTH  bank state (cell outputs)
- BUSY  output  1  command in progress
- DONE  output  1  one-cycle completion pulse

## Operation
- One clock domain. Reset is asynchronous and active-low.
- Command fields are latched on a clock edge where CMD_VALID && CMD_READY. CMD_VALID while not ready is ignored; the requester holds it.
- FSM states: IDLE, APPLY, COUNT, DONE.
- IDLE: CMD_READY=1, J=K=0 on all cells. On accept: HOLD/SET/CLEAR → APPLY; COUNT with CMD_COUNT>0 → COUNT; COUNT with CMD_COUNT=0 → DONE.
- APPLY lasts exactly one cycle, then goes to DONE.
  - SET: J=mask, K=0.
  - CLEAR: J=0, K=mask.
  - HOLD: J=K=0.
- COUNT: each cycle T[0]=1 and T[i]=&Q[i-1:0]; J[i]=K[i]=T[i].
  - Remaining-step counter loads CMD_COUNT and decrements once per cycle.
  - Go to DONE when the counter equals 1.
  - Q wraps modulo 2^WIDTH (all-ones → zero).
- DONE: DONE=1 for one cycle, J=K=0, then IDLE.
- Outputs are combinational from state:
  - CMD_READY = (state==IDLE)
  - BUSY = (state!=IDLE)
  - DONE = (state==DONE)
- Reset values: Q=0, state IDLE, counter 0, BUSY=0, DONE=0, CMD_READY=1. No command is accepted while RST_N is low.
- Reset mid-command aborts it. Q clears to 0 immediately, no DONE pulse is produced, and the latched command is discarded.

## Timing
Accept edge is t.
- SET/CLEAR/HOLD: Q updates at edge t+1. DONE is high in cycle t+1..t+2. CMD_READY returns after edge t+2, so throughput is one command per 3 cycles.
- COUNT N (N≥1): Q increments at edges t+1..t+N. DONE is high in cycle t+N..t+N+1. Ready again after edge t+N+1.
- COUNT 0: Q is unchanged. DONE is high in cycle t..t+1. Ready after edge t+1.
- Q changes only on rising CLK edges or on RST_N assertion.
- DONE and CMD_READY are never high in the same cycle.
- RST_N deassertion is synchronous to the design. The first command can be accepted at the first rising edge with RST_N high.

## Structure
- Package jk_ctrl_pkg holds:
  - op encodings OP_HOLD/OP_SET/OP_CLEAR/OP_COUNT
  - FSM state encodings S_IDLE/S_APPLY/S_COUNT/S_DONE
- Sub-module jk_cell is a single JK flip-flop with asynchronous active-low reset.
  - Ports: CLK, RST_N, J, K, Q.
  - Behaviour: 00 hold, 10 set, 01 clear, 11 toggle.
  - Instantiated WIDTH times via generate.
- Top level contains the FSM, command latch, step counter and J/K generation.

## Test plan
All scenarios use WIDTH=4.
1. Reset: assert RST_N=0 for 3 cycles → Q=0000, CMD_READY=1, BUSY=0, DONE=0. Drive CMD_VALID=1 during reset → not accepted.
2. SET: from Q=0000, SET mask 1010 → Q=1010 one edge after accept. DONE pulses exactly one cycle. CMD_READY is back two cycles after accept.
3. CLEAR then HOLD: from Q=1010, CLEAR mask 0010 → Q=1000. Then HOLD mask 1111 → Q stays 1000, DONE pulses.
4. COUNT with wrap: from Q=1110, COUNT 5 → Q sequence 1111, 0000, 0001, 0010, 0011 on consecutive edges. Single DONE pulse. BUSY high for 6 cycles.
5. COUNT 0 and back-pressure: COUNT 0 → Q unchanged, DONE in the cycle after accept. Then present a second command while BUSY → it is not accepted until CMD_READY=1, and executes exactly once.
6. Reset mid-operation: COUNT 10 from 0000, pull RST_N low after 3 edges (Q=0011) → Q=0000 immediately, no DONE. After release, CMD_READY=1 and a new SET 0001 gives Q=0001.
